// File: rtl/instr_encoder_pkg.sv
// Shared constants for the instruction encoder.
//   - 8-bit canonical op codes {word[15:12], word[7:4]} (same values the decoder uses)
//   - I-type opcode nibbles, plus the LUI/ORI nibbles used for wide-immediate expansion
//   - encoder FSM state enum
package instr_encoder_pkg;

    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_MOV  = 8'h0D;
    localparam logic [7:0] OP_MUL  = 8'h0E;
    localparam logic [7:0] OP_LSH  = 8'h84;
    localparam logic [7:0] OP_ASHU = 8'h86;

    // Immediate-form nibbles: signed-immediate group
    localparam logic [3:0] NIB_ADDI = 4'b0101;
    localparam logic [3:0] NIB_SUBI = 4'b1001;
    localparam logic [3:0] NIB_CMPI = 4'b1011;
    localparam logic [3:0] NIB_MULI = 4'b1110;
    // Immediate-form nibbles: unsigned-immediate group
    localparam logic [3:0] NIB_ANDI = 4'b0001;
    localparam logic [3:0] NIB_ORI  = 4'b0010;
    localparam logic [3:0] NIB_XORI = 4'b0011;
    localparam logic [3:0] NIB_MOVI = 4'b1101;
    // Load-upper-immediate
    localparam logic [3:0] NIB_LUI  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2,
        ST_W2   = 2'd3
    } state_t;

endpackage

// File: rtl/instr_encoder_fit_check.sv
// Combinational classifier for one encoder request.
//   op, ri, r_dest, r_src_msb, imm : request fields
//   nibble     : I-type opcode nibble for op (0 when op has no immediate form)
//   word_count : number of words the request expands to (1..3)
//   reject     : request is illegal and must produce no words
import instr_encoder_pkg::*;

module instr_fit_check #(
    parameter logic [3:0] SCRATCH = 4'd15
) (
    input  logic [7:0]  op,
    input  logic        ri,
    input  logic [4:0]  r_dest,
    input  logic        r_src_msb,
    input  logic [15:0] imm,
    output logic [3:0]  nibble,
    output logic [1:0]  word_count,
    output logic        reject
);

    logic known;
    logic is_signed;
    logic is_shift;
    logic fits;

    always_comb begin
        nibble    = 4'd0;
        known     = 1'b1;
        is_signed = 1'b0;
        is_shift  = 1'b0;
        case (op)
            OP_ADD:  begin nibble = NIB_ADDI; is_signed = 1'b1; end
            OP_SUB:  begin nibble = NIB_SUBI; is_signed = 1'b1; end
            OP_CMP:  begin nibble = NIB_CMPI; is_signed = 1'b1; end
            OP_MUL:  begin nibble = NIB_MULI; is_signed = 1'b1; end
            OP_AND:  nibble = NIB_ANDI;
            OP_OR:   nibble = NIB_ORI;
            OP_XOR:  nibble = NIB_XORI;
            OP_MOV:  nibble = NIB_MOVI;
            OP_LSH,
            OP_ASHU: is_shift = 1'b1;
            default: known = 1'b0;
        endcase
    end

    // Signed immediates fit when the high byte is pure sign extension of bit 7
    assign fits = is_signed ? (imm[15:8] == {8{imm[7]}}) : (imm[15:8] == 8'h00);

    always_comb begin
        word_count = 2'd1;
        if (ri && !fits) begin
            word_count = (op == OP_MOV) ? 2'd2 : 2'd3;
        end
    end

    // The 3-word form clobbers SCRATCH, so it cannot also be the destination
    assign reject = !known
                  || (ri && is_shift)
                  || r_dest[4]
                  || (!ri && r_src_msb)
                  || ((word_count == 2'd3) && (r_dest[3:0] == SCRATCH));

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded-form operations into 16-bit instruction words with an
// auto-incrementing instruction-memory write address. Wide immediates expand
// to LUI/ORI (MOV) or LUI/ORI/R-type through SCRATCH.
//   clk, reset (async, active-low)
//   op_in, RI_in, R_dest, R_src, immediate, in_valid / in_ready : request side
//   instr_out, instr_addr, out_valid / out_ready              : word output side
//   addr_load, addr_in : reload of the address counter (IDLE only)
//   err                : one-cycle pulse after a rejected request
import instr_encoder_pkg::*;

module instr_encoder #(
    parameter int         ADDR_W  = 8,
    parameter logic [3:0] SCRATCH = 4'd15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        op_in,
    input  logic              RI_in,
    input  logic [4:0]        R_dest,
    input  logic [4:0]        R_src,
    input  logic [15:0]       immediate,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [15:0]       instr_out,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              err
);

    state_t            state_reg, state_next;
    logic [15:0]       word_reg [3];
    logic [15:0]       new_word [3];
    logic [1:0]        count_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              err_reg;

    logic [3:0]        nibble;
    logic [1:0]        word_count;
    logic              reject;
    logic              idle;
    logic              accept;

    instr_fit_check #(.SCRATCH(SCRATCH)) u_fit_check (
        .op         (op_in),
        .ri         (RI_in),
        .r_dest     (R_dest),
        .r_src_msb  (R_src[4]),
        .imm        (immediate),
        .nibble     (nibble),
        .word_count (word_count),
        .reject     (reject)
    );

    assign idle   = (state_reg == ST_IDLE);
    assign accept = idle && in_valid && !reject;

    // Full word sequence for the incoming request, captured at acceptance
    always_comb begin
        new_word[0] = 16'h0000;
        new_word[1] = 16'h0000;
        new_word[2] = 16'h0000;
        case (word_count)
            2'd2: begin
                new_word[0] = {NIB_LUI, R_dest[3:0], immediate[15:8]};
                new_word[1] = {NIB_ORI, R_dest[3:0], immediate[7:0]};
            end
            2'd3: begin
                new_word[0] = {NIB_LUI, SCRATCH, immediate[15:8]};
                new_word[1] = {NIB_ORI, SCRATCH, immediate[7:0]};
                new_word[2] = {op_in[7:4], R_dest[3:0], op_in[3:0], SCRATCH};
            end
            default: begin
                new_word[0] = RI_in ? {nibble, R_dest[3:0], immediate[7:0]}
                                    : {op_in[7:4], R_dest[3:0], op_in[3:0], R_src[3:0]};
            end
        endcase
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_word
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                word_reg[gi] <= 16'h0000;
            end else if (accept) begin
                word_reg[gi] <= new_word[gi];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= 2'd0;
            addr_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= idle && in_valid && reject;
            if (accept) begin
                count_reg <= word_count;
            end
            // A load in IDLE wins; a request accepted on the same edge starts at addr_in
            if (idle && addr_load) begin
                addr_reg <= addr_in;
            end else if (out_valid && out_ready) begin
                addr_reg <= addr_reg + ADDR_W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)    state_next = ST_W0;
            ST_W0:   if (out_ready) state_next = (count_reg == 2'd1) ? ST_IDLE : ST_W1;
            ST_W1:   if (out_ready) state_next = (count_reg == 2'd2) ? ST_IDLE : ST_W2;
            ST_W2:   if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready   = idle;
        out_valid  = !idle;
        instr_addr = addr_reg;
        err        = err_reg;
        case (state_reg)
            ST_W0:   instr_out = word_reg[0];
            ST_W1:   instr_out = word_reg[1];
            ST_W2:   instr_out = word_reg[2];
            default: instr_out = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  op_in;
    logic        RI_in;
    logic [4:0]  R_dest;
    logic [4:0]  R_src;
    logic [15:0] immediate;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr_out;
    logic [7:0]  instr_addr;
    logic        out_valid;
    logic        out_ready;
    logic        addr_load;
    logic [7:0]  addr_in;
    logic        err;

    int          tot = 0;
    int          bad = 0;
    logic [7:0]  exp_addr = 8'h00;

    instr_encoder #(.ADDR_W(8), .SCRATCH(4'd15)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_in      (op_in),
        .RI_in      (RI_in),
        .R_dest     (R_dest),
        .R_src      (R_src),
        .immediate  (immediate),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr_out  (instr_out),
        .instr_addr (instr_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .addr_load  (addr_load),
        .addr_in    (addr_in),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Reference model: expected word list straight from the encoding rules
    function automatic void model(input logic [7:0] op, input logic ri, input logic [4:0] rd,
                                  input logic [4:0] rs, input logic [15:0] imm,
                                  output logic rej, output int n,
                                  output logic [15:0] w0, output logic [15:0] w1, output logic [15:0] w2);
        bit known, sgn, shift, fit;
        int simm;
        known = op inside {8'h05, 8'h09, 8'h0E, 8'h02, 8'h0B, 8'h01, 8'h03, 8'h0D, 8'h84, 8'h86};
        sgn   = op inside {8'h05, 8'h09, 8'h0B, 8'h0E};
        shift = op inside {8'h84, 8'h86};
        simm  = int'($signed(imm));
        fit   = sgn ? (simm >= -128 && simm <= 127) : (int'(imm) < 256);
        w0 = 16'h0; w1 = 16'h0; w2 = 16'h0;
        if (!ri) begin
            n = 1; w0 = {op[7:4], rd[3:0], op[3:0], rs[3:0]};
        end else if (fit) begin
            // every listed op's I-type nibble equals its low canonical nibble
            n = 1; w0 = {op[3:0], rd[3:0], imm[7:0]};
        end else if (op == 8'h0D) begin
            n = 2; w0 = {4'hF, rd[3:0], imm[15:8]}; w1 = {4'h2, rd[3:0], imm[7:0]};
        end else begin
            n = 3; w0 = {4'hF, 4'hF, imm[15:8]}; w1 = {4'h2, 4'hF, imm[7:0]};
            w2 = {op[7:4], rd[3:0], op[3:0], 4'hF};
        end
        rej = !known || (ri && shift) || rd[4] || (!ri && rs[4]) || (n == 3 && rd[3:0] == 4'hF);
        if (rej) n = 0;
    endfunction

    // Present one request for exactly one accepting edge, then scramble the fields
    task automatic issue(input logic [7:0] op, input logic ri, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [15:0] imm);
        int c = 0;
        while (in_ready !== 1'b1 && c < 20) begin
            @(posedge clk); #1; c++;
        end
        tot++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL issue_ready in_ready=%b required 1", in_ready);
        end
        op_in = op; RI_in = ri; R_dest = rd; R_src = rs; immediate = imm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_in = 8'($urandom); RI_in = 1'($urandom); R_dest = 5'($urandom);
        R_src = 5'($urandom); immediate = 16'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b0; op_in = 8'h0; RI_in = 1'b0; R_dest = 5'h0; R_src = 5'h0; immediate = 16'h0;
        in_valid = 1'b0; out_ready = 1'b0; addr_load = 1'b0; addr_in = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        tot++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || instr_out !== 16'h0 || instr_addr !== 8'h0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state in_ready=%b out_valid=%b instr=%h addr=%h err=%b required 1 0 0000 00 0",
                     in_ready, out_valid, instr_out, instr_addr, err);
        end
        #2 reset = 1'b1;
        @(posedge clk); #1;
        exp_addr = 8'h00;
    endtask

    task automatic test_rtype();
        issue(8'h05, 1'b0, 5'd3, 5'd4, 16'h0);
        out_ready = 1'b1;
        tot++;
        if (out_valid !== 1'b1 || instr_out !== 16'h0354 || instr_addr !== exp_addr || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rtype_word valid=%b instr=%h addr=%h in_ready=%b required 1 0354 %h 0",
                     out_valid, instr_out, instr_addr, in_ready, exp_addr);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_addr = exp_addr + 8'd1;
        tot++;
        if (out_valid !== 1'b0 || instr_addr !== exp_addr || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rtype_after valid=%b addr=%h in_ready=%b required 0 %h 1",
                     out_valid, instr_addr, in_ready, exp_addr);
        end
    endtask

    task automatic test_immediate();
        logic [15:0] ew [3];
        issue(8'h05, 1'b1, 5'd2, 5'd0, 16'hFFFD);
        out_ready = 1'b1;
        tot++;
        if (out_valid !== 1'b1 || instr_out !== 16'h52FD || instr_addr !== exp_addr) begin
            bad++;
            $display("FAIL addi_word valid=%b instr=%h addr=%h required 1 52fd %h",
                     out_valid, instr_out, instr_addr, exp_addr);
        end
        @(posedge clk); #1;
        exp_addr = exp_addr + 8'd1;
        ew = '{16'hFF12, 16'h2F34, 16'h012F};
        issue(8'h02, 1'b1, 5'd1, 5'd0, 16'h1234);
        for (int k = 0; k < 3; k++) begin
            tot++;
            if (out_valid !== 1'b1 || instr_out !== ew[k] || instr_addr !== exp_addr) begin
                bad++;
                $display("FAIL or_wide_word%0d valid=%b instr=%h addr=%h required 1 %h %h",
                         k, out_valid, instr_out, instr_addr, ew[k], exp_addr);
            end
            @(posedge clk); #1;
            exp_addr = exp_addr + 8'd1;
        end
        out_ready = 1'b0;
        tot++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL or_wide_end valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        issue(8'h0D, 1'b1, 5'd5, 5'd0, 16'h0180);
        out_ready = 1'b0;
        addr_load = 1'b1; addr_in = 8'h55;   // must be ignored outside IDLE
        for (int s = 0; s < 3; s++) begin
            tot++;
            if (out_valid !== 1'b1 || instr_out !== 16'hF501 || instr_addr !== exp_addr) begin
                bad++;
                $display("FAIL mov_stall%0d valid=%b instr=%h addr=%h required 1 f501 %h",
                         s, out_valid, instr_out, instr_addr, exp_addr);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        tot++;
        if (out_valid !== 1'b1 || instr_out !== 16'hF501 || instr_addr !== exp_addr) begin
            bad++;
            $display("FAIL mov_word0 valid=%b instr=%h addr=%h required 1 f501 %h",
                     out_valid, instr_out, instr_addr, exp_addr);
        end
        @(posedge clk); #1;
        exp_addr = exp_addr + 8'd1;
        tot++;
        if (out_valid !== 1'b1 || instr_out !== 16'h2580 || instr_addr !== exp_addr) begin
            bad++;
            $display("FAIL mov_word1 valid=%b instr=%h addr=%h required 1 2580 %h",
                     out_valid, instr_out, instr_addr, exp_addr);
        end
        addr_load = 1'b0;
        @(posedge clk); #1;
        exp_addr = exp_addr + 8'd1;
        out_ready = 1'b0;
        tot++;
        if (out_valid !== 1'b0 || instr_addr !== exp_addr) begin
            bad++; $display("FAIL mov_end valid=%b addr=%h required 0 %h", out_valid, instr_addr, exp_addr);
        end
    endtask

    task automatic test_reject();
        logic [7:0]  rop [4];
        logic        rri [4];
        logic [4:0]  rrd [4];
        logic [15:0] rimm [4];
        rop = '{8'h84, 8'h05, 8'h07, 8'h03};
        rri = '{1'b1, 1'b1, 1'b0, 1'b1};
        rrd = '{5'd1, 5'd15, 5'd2, 5'd18};
        rimm = '{16'h0003, 16'h4000, 16'h0000, 16'h0001};
        for (int k = 0; k < 4; k++) begin
            issue(rop[k], rri[k], rrd[k], 5'd1, rimm[k]);
            tot++;
            if (err !== 1'b1 || out_valid !== 1'b0) begin
                bad++; $display("FAIL reject%0d_pulse err=%b valid=%b required 1 0", k, err, out_valid);
            end
            @(posedge clk); #1;
            tot++;
            if (err !== 1'b0 || out_valid !== 1'b0 || instr_addr !== exp_addr || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL reject%0d_after err=%b valid=%b addr=%h in_ready=%b required 0 0 %h 1",
                         k, err, out_valid, instr_addr, in_ready, exp_addr);
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic [7:0] ea [2];
        ea = '{8'hFF, 8'h00};
        addr_load = 1'b1; addr_in = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            issue(8'h03, 1'b0, 5'(k + 6), 5'd7, 16'h0);
            addr_load = 1'b0;
            out_ready = 1'b1;
            tot++;
            if (out_valid !== 1'b1 || instr_addr !== ea[k] || instr_out !== {4'h0, 4'(k + 6), 4'h3, 4'h7}) begin
                bad++;
                $display("FAIL wrap%0d valid=%b addr=%h instr=%h required 1 %h %h", k, out_valid,
                         instr_addr, instr_out, ea[k], {4'h0, 4'(k + 6), 4'h3, 4'h7});
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        exp_addr = 8'h01;
        tot++;
        if (instr_addr !== exp_addr) begin
            bad++; $display("FAIL wrap_final addr=%h required %h", instr_addr, exp_addr);
        end
    endtask

    task automatic test_reset_mid();
        issue(8'h02, 1'b1, 5'd1, 5'd0, 16'h1234);
        out_ready = 1'b1;
        @(posedge clk); #1;           // first word consumed, now on the second
        reset = 1'b0;
        #2;
        tot++;
        if (out_valid !== 1'b0 || instr_addr !== 8'h00 || instr_out !== 16'h0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid valid=%b addr=%h instr=%h in_ready=%b required 0 00 0000 1",
                     out_valid, instr_addr, instr_out, in_ready);
        end
        #1 reset = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        exp_addr = 8'h00;
        tot++;
        if (out_valid !== 1'b0 || instr_addr !== exp_addr) begin
            bad++; $display("FAIL reset_mid_after valid=%b addr=%h required 0 %h", out_valid, instr_addr, exp_addr);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [11];
        pool = '{8'h05, 8'h09, 8'h0E, 8'h02, 8'h0B, 8'h01, 8'h03, 8'h0D, 8'h84, 8'h86, 8'h07};
        for (int it = 0; it < 200; it++) begin
            logic [7:0]  op;
            logic        ri, rej;
            logic [4:0]  rd, rs;
            logic [15:0] imm;
            logic [15:0] ew [3];
            int          n, stalls, mode;
            op = pool[$urandom_range(0, 10)];
            ri = 1'($urandom);
            rd = 5'($urandom_range(0, 15)) | (($urandom_range(0, 15) == 0) ? 5'h10 : 5'h00);
            rs = 5'($urandom_range(0, 15)) | (($urandom_range(0, 15) == 0) ? 5'h10 : 5'h00);
            mode = $urandom_range(0, 2);
            imm = (mode == 0) ? 16'($urandom_range(0, 255))
                : (mode == 1) ? (16'hFF80 | 16'($urandom_range(0, 127))) : 16'($urandom);
            model(op, ri, rd, rs, imm, rej, n, ew[0], ew[1], ew[2]);
            if ($urandom_range(0, 7) == 0) begin
                addr_load = 1'b1; addr_in = 8'($urandom); exp_addr = addr_in;
            end
            issue(op, ri, rd, rs, imm);
            addr_load = 1'b0;
            if (rej) begin
                tot++;
                if (err !== 1'b1 || out_valid !== 1'b0) begin
                    bad++; $display("FAIL rnd%0d_reject err=%b valid=%b required 1 0", it, err, out_valid);
                end
                @(posedge clk); #1;
            end
            for (int k = 0; k < n; k++) begin
                stalls = 0;
                out_ready = 1'b0;
                while (out_ready !== 1'b1) begin
                    out_ready = (stalls >= 4) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
                    tot++;
                    if (out_valid !== 1'b1 || instr_out !== ew[k] || instr_addr !== exp_addr
                        || in_ready !== 1'b0 || err !== 1'b0) begin
                        bad++;
                        $display("FAIL rnd%0d_word%0d op=%h ri=%b rd=%0d imm=%h valid=%b instr=%h addr=%h in_ready=%b err=%b required 1 %h %h 0 0",
                                 it, k, op, ri, rd, imm, out_valid, instr_out, instr_addr, in_ready, err, ew[k], exp_addr);
                    end
                    @(posedge clk); #1;
                    stalls++;
                end
                exp_addr = exp_addr + 8'd1;
            end
            out_ready = 1'b0;
            tot++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0 || instr_addr !== exp_addr) begin
                bad++;
                $display("FAIL rnd%0d_idle valid=%b in_ready=%b err=%b addr=%h required 0 1 0 %h",
                         it, out_valid, in_ready, err, instr_addr, exp_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_immediate();
        test_backpressure();
        test_reject();
        test_addr_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
